// File: rtl/mccu_pkg.sv
// Shared definitions for the multi-cycle control unit: state codes, ALU
// control codes, datapath select codes, MIPS opcode/funct values and the
// one-hot instruction flag bundle produced by the decoder.
package mccu_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_e;

    // ALU operation codes
    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_LUI = 4'b0110;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;

    // ALU B operand select
    localparam logic [1:0] ALUB_RT   = 2'b00;
    localparam logic [1:0] ALUB_FOUR = 2'b01;
    localparam logic [1:0] ALUB_IMM  = 2'b10;
    localparam logic [1:0] ALUB_BR   = 2'b11;

    // Next-PC source select
    localparam logic [1:0] PCS_ALU = 2'b00;
    localparam logic [1:0] PCS_BR  = 2'b01;
    localparam logic [1:0] PCS_RS  = 2'b10;
    localparam logic [1:0] PCS_JMP = 2'b11;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;

    // One-hot instruction flags (at most one bit set)
    typedef struct packed {
        logic i_add;
        logic i_sub;
        logic i_and;
        logic i_or;
        logic i_xor;
        logic i_sll;
        logic i_srl;
        logic i_sra;
        logic i_sllv;
        logic i_srlv;
        logic i_srav;
        logic i_jr;
        logic i_addi;
        logic i_andi;
        logic i_ori;
        logic i_xori;
        logic i_lui;
        logic i_lw;
        logic i_sw;
        logic i_beq;
        logic i_bne;
        logic i_j;
        logic i_jal;
    } instr_t;

endpackage

// File: rtl/mccu_decode.sv
// Combinational instruction decoder: op/func to one-hot instruction flags,
// with an illegal flag for any encoding outside the supported subset.
module mccu_decode
    import mccu_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output instr_t     dec,
    output logic       illegal
);

    // Decode op, then func for R-type; anything unmatched is illegal
    always_comb begin
        dec     = '0;
        illegal = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (func)
                    F_ADD:   dec.i_add  = 1'b1;
                    F_SUB:   dec.i_sub  = 1'b1;
                    F_AND:   dec.i_and  = 1'b1;
                    F_OR:    dec.i_or   = 1'b1;
                    F_XOR:   dec.i_xor  = 1'b1;
                    F_SLL:   dec.i_sll  = 1'b1;
                    F_SRL:   dec.i_srl  = 1'b1;
                    F_SRA:   dec.i_sra  = 1'b1;
                    F_SLLV:  dec.i_sllv = 1'b1;
                    F_SRLV:  dec.i_srlv = 1'b1;
                    F_SRAV:  dec.i_srav = 1'b1;
                    F_JR:    dec.i_jr   = 1'b1;
                    default: illegal    = 1'b1;
                endcase
            end
            OP_ADDI: dec.i_addi = 1'b1;
            OP_ANDI: dec.i_andi = 1'b1;
            OP_ORI:  dec.i_ori  = 1'b1;
            OP_XORI: dec.i_xori = 1'b1;
            OP_LUI:  dec.i_lui  = 1'b1;
            OP_LW:   dec.i_lw   = 1'b1;
            OP_SW:   dec.i_sw   = 1'b1;
            OP_BEQ:  dec.i_beq  = 1'b1;
            OP_BNE:  dec.i_bne  = 1'b1;
            OP_J:    dec.i_j    = 1'b1;
            OP_JAL:  dec.i_jal  = 1'b1;
            default: illegal    = 1'b1;
        endcase
    end

endmodule

// File: rtl/mccu_fsm.sv
// Multi-cycle control unit: sequences a shared ALU / unified memory datapath
// through IF/ID/EXE/MEM/WB, driving write enables, mux selects and ALU
// control combinationally from the current state and instruction.
// Optional macro MCCU_PERF_EN adds cycle and retired-instruction counters.
module mccu_fsm
    import mccu_pkg::*;
#(
    parameter int ST_W  = 3,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             z,
    input  logic             mem_rdy,
    output logic             wpc,
    output logic             wir,
    output logic             wmem,
    output logic             wreg,
    output logic             iord,
    output logic             regrt,
    output logic             m2reg,
    output logic             jal,
    output logic             shift,
    output logic             sext,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [3:0]       aluc,
    output logic [1:0]       pcsource,
    output logic [ST_W-1:0]  state
`ifdef MCCU_PERF_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    state_e state_q, state_d;
    instr_t dec;
    logic   illegal;
    logic   itype;

    mccu_decode u_decode (
        .op      (op),
        .func    (func),
        .dec     (dec),
        .illegal (illegal)
    );

    assign itype = dec.i_addi | dec.i_andi | dec.i_ori | dec.i_xori | dec.i_lui;
    assign state = ST_W'(state_q);

    // State register; reset lands in IF on the next edge
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IF;
        else     state_q <= state_d;
    end

    // Next-state and per-state control outputs; every output defaults to 0
    always_comb begin
        state_d  = S_IF;
        wpc      = 1'b0;
        wir      = 1'b0;
        wmem     = 1'b0;
        wreg     = 1'b0;
        iord     = 1'b0;
        regrt    = 1'b0;
        m2reg    = 1'b0;
        jal      = 1'b0;
        shift    = 1'b0;
        sext     = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = ALUB_RT;
        aluc     = ALUC_ADD;
        pcsource = PCS_ALU;
        case (state_q)
            S_IF: begin
                // PC+4 through the ALU while fetching; commit only when memory answers
                alusrcb = ALUB_FOUR;
                wir     = mem_rdy;
                wpc     = mem_rdy;
                state_d = mem_rdy ? S_ID : S_IF;
            end
            S_ID: begin
                // ALU computes the branch target speculatively for EXE
                alusrcb = ALUB_BR;
                sext    = 1'b1;
                if (dec.i_j) begin
                    pcsource = PCS_JMP;
                    wpc      = 1'b1;
                end else if (dec.i_jal) begin
                    pcsource = PCS_JMP;
                    wpc      = 1'b1;
                    wreg     = 1'b1;
                    jal      = 1'b1;
                end else if (dec.i_jr) begin
                    pcsource = PCS_RS;
                    wpc      = 1'b1;
                end else if (!illegal) begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                alusrca = 1'b1;
                if (dec.i_beq || dec.i_bne) begin
                    aluc     = ALUC_SUB;
                    pcsource = PCS_BR;
                    wpc      = dec.i_beq ? z : ~z;
                end else if (dec.i_lw || dec.i_sw) begin
                    alusrcb = ALUB_IMM;
                    sext    = 1'b1;
                    state_d = S_MEM;
                end else begin
                    alusrcb = itype ? ALUB_IMM : ALUB_RT;
                    sext    = dec.i_addi;
                    shift   = dec.i_sll | dec.i_srl | dec.i_sra;
                    if (dec.i_add || dec.i_addi)                   aluc = ALUC_ADD;
                    else if (dec.i_sub)                            aluc = ALUC_SUB;
                    else if (dec.i_and || dec.i_andi)              aluc = ALUC_AND;
                    else if (dec.i_or || dec.i_ori)                aluc = ALUC_OR;
                    else if (dec.i_xor || dec.i_xori)              aluc = ALUC_XOR;
                    else if (dec.i_lui)                            aluc = ALUC_LUI;
                    else if (dec.i_sll || dec.i_sllv)              aluc = ALUC_SLL;
                    else if (dec.i_srl || dec.i_srlv)              aluc = ALUC_SRL;
                    else if (dec.i_sra || dec.i_srav)              aluc = ALUC_SRA;
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                // Store strobe stays up until the memory accepts it
                iord = 1'b1;
                if (dec.i_sw) begin
                    wmem    = 1'b1;
                    state_d = mem_rdy ? S_IF : S_MEM;
                end else if (dec.i_lw) begin
                    state_d = mem_rdy ? S_WB : S_MEM;
                end
            end
            S_WB: begin
                wreg  = 1'b1;
                regrt = itype | dec.i_lw;
                m2reg = dec.i_lw;
            end
            default: state_d = S_IF;
        endcase
        // Reset suppresses every architectural write, abandoning any instruction
        if (rst) begin
            wpc     = 1'b0;
            wir     = 1'b0;
            wmem    = 1'b0;
            wreg    = 1'b0;
            state_d = S_IF;
        end
    end

`ifdef MCCU_PERF_EN
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;
    logic             retire;

    // An instruction retires whenever a non-fetch state hands back to IF
    always_comb begin
        retire        = (state_q inside {S_ID, S_EXE, S_MEM, S_WB}) && (state_d == S_IF);
        cyc_cnt_d     = cyc_cnt_q + CNT_W'(1);
        instret_cnt_d = instret_cnt_q + CNT_W'(retire);
    end

    // Counter registers, cleared by reset, free-running modulo 2^CNT_W
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt_q     <= '0;
            instret_cnt_q <= '0;
        end else begin
            cyc_cnt_q     <= cyc_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cyc_cnt     = cyc_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_mccu_fsm.sv
// Scoreboard bench for mccu_fsm: a driver expands each instruction into its
// expected per-cycle control vectors from the instruction-set timing rules,
// queues them, and a negedge monitor compares them against the DUT.
module tb_mccu_fsm;

    logic        clk = 1'b0;
    logic        rst, z, mem_rdy;
    logic [5:0]  op, func;
    logic        wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, sext, alusrca;
    logic [1:0]  alusrcb, pcsource;
    logic [3:0]  aluc;
    logic [2:0]  state;
`ifdef MCCU_PERF_EN
    logic [31:0] cyc_cnt, instret_cnt;
`endif

    always #5 clk = ~clk;

    mccu_fsm #(.ST_W(3), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .op(op), .func(func), .z(z), .mem_rdy(mem_rdy),
        .wpc(wpc), .wir(wir), .wmem(wmem), .wreg(wreg), .iord(iord), .regrt(regrt),
        .m2reg(m2reg), .jal(jal), .shift(shift), .sext(sext), .alusrca(alusrca),
        .alusrcb(alusrcb), .aluc(aluc), .pcsource(pcsource), .state(state)
`ifdef MCCU_PERF_EN
        , .cyc_cnt(cyc_cnt), .instret_cnt(instret_cnt)
`endif
    );

    typedef struct packed {
        logic wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, sext, alusrca;
        logic [1:0] alusrcb;
        logic [3:0] aluc;
        logic [1:0] pcsource;
    } outs_t;

    typedef struct {
        logic [2:0]  st;
        outs_t       o;
        bit          en_only;
        int unsigned cyc;
        int unsigned ins;
    } rec_t;

    rec_t        sb[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int unsigned m_cyc  = 0;
    int unsigned m_ins  = 0;

    // Instruction classes of the reference model
    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5,
                   K_J = 6, K_JAL = 7, K_JR = 8, K_ILL = 9;
    localparam int NI = 25;

    logic [5:0] t_op [NI] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                             6'h00, 6'h00, 6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23,
                             6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3F, 6'h00};
    logic [5:0] t_fn [NI] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02, 6'h03, 6'h04,
                             6'h06, 6'h07, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                             6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h01};
    int         t_k  [NI] = '{K_R, K_R, K_R, K_R, K_R, K_R, K_R, K_R, K_R, K_R, K_R, K_JR,
                             K_I, K_I, K_I, K_I, K_I, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL,
                             K_ILL, K_ILL};
    logic [3:0] t_alu[NI] = '{4'b0000, 4'b0100, 4'b0001, 4'b0101, 4'b0010, 4'b0011, 4'b0111,
                             4'b1111, 4'b0011, 4'b0111, 4'b1111, 4'b0000, 4'b0000, 4'b0001,
                             4'b0101, 4'b0010, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                             4'b0000, 4'b0000, 4'b0000, 4'b0000};
    bit         t_sh [NI] = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // Drive one cycle's inputs and queue the response expected for it
    task automatic cyc(input logic r, input logic mr, input logic zz, input logic [5:0] o_p,
                       input logic [5:0] f_p, input logic [2:0] st, input outs_t o,
                       input bit eo, input bit ret);
        rec_t e;
        @(posedge clk); #1;
        rst = r; mem_rdy = mr; z = zz; op = o_p; func = f_p;
        e.st = st; e.o = o; e.en_only = eo; e.cyc = m_cyc; e.ins = m_ins;
        sb.push_back(e);
        if (r) begin
            m_cyc = 0; m_ins = 0;
        end else begin
            m_cyc++;
            if (ret) m_ins++;
        end
    endtask

    // Expand one instruction into its cycle-by-cycle expected behaviour
    task automatic run_instr(input int k, input int ifw, input int memw, input logic zb,
                             input bit abort_mem);
        outs_t      o;
        logic [5:0] p, f;
        int         kd;
        kd = t_k[k];
        p  = t_op[k];
        f  = (p == 6'h00) ? t_fn[k] : 6'($urandom);
        for (int i = 0; i < ifw; i++) begin
            o = '0; o.alusrcb = 2'b01;
            cyc(0, 0, rb(), p, f, 3'd0, o, 0, 0);
        end
        o = '0; o.alusrcb = 2'b01; o.wpc = 1; o.wir = 1;
        cyc(0, 1, rb(), p, f, 3'd0, o, 0, 0);
        // decode cycle: jumps and illegal encodings finish here
        o = '0; o.alusrcb = 2'b11; o.sext = 1;
        if (kd == K_J || kd == K_JAL) begin o.pcsource = 2'b11; o.wpc = 1; end
        if (kd == K_JAL) begin o.wreg = 1; o.jal = 1; end
        if (kd == K_JR) begin o.pcsource = 2'b10; o.wpc = 1; end
        if (kd == K_J || kd == K_JAL || kd == K_JR || kd == K_ILL) begin
            cyc(0, rb(), rb(), p, f, 3'd1, o, 0, 1);
            return;
        end
        cyc(0, rb(), rb(), p, f, 3'd1, o, 0, 0);
        o = '0; o.alusrca = 1;
        if (kd == K_BEQ || kd == K_BNE) begin
            o.aluc = 4'b0100; o.pcsource = 2'b01;
            o.wpc = (kd == K_BEQ) ? zb : !zb;
            cyc(0, rb(), zb, p, f, 3'd2, o, 0, 1);
            return;
        end
        if (kd == K_LW || kd == K_SW) begin
            o.alusrcb = 2'b10; o.sext = 1;
            cyc(0, rb(), rb(), p, f, 3'd2, o, 0, 0);
            for (int i = 0; i < memw; i++) begin
                o = '0; o.iord = 1; o.wmem = (kd == K_SW);
                cyc(0, 0, rb(), p, f, 3'd3, o, 0, 0);
            end
            if (abort_mem) begin
                cyc(1, 1, rb(), p, f, 3'd0, '0, 1, 0);
                return;
            end
            o = '0; o.iord = 1; o.wmem = (kd == K_SW);
            cyc(0, 1, rb(), p, f, 3'd3, o, 0, kd == K_SW);
            if (kd == K_SW) return;
        end else begin
            o.aluc = t_alu[k]; o.shift = t_sh[k]; o.sext = (k == 12);
            o.alusrcb = (kd == K_I) ? 2'b10 : 2'b00;
            cyc(0, rb(), rb(), p, f, 3'd2, o, 0, 0);
        end
        o = '0; o.wreg = 1; o.regrt = (kd == K_I || kd == K_LW); o.m2reg = (kd == K_LW);
        cyc(0, rb(), rb(), p, f, 3'd4, o, 0, 1);
    endtask

    // Monitor: pop one expectation per cycle and compare against the DUT
    always @(negedge clk) begin
        rec_t  e;
        outs_t a;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            a = {wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift, sext, alusrca,
                 alusrcb, aluc, pcsource};
            n_chk++;
            if (e.en_only) begin
                if ({a.wpc, a.wir, a.wmem, a.wreg} !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL reset_enables t=%0t: got wpc/wir/wmem/wreg=%b, expected 0000",
                             $time, {a.wpc, a.wir, a.wmem, a.wreg});
                end
            end else begin
                if (state !== e.st || a !== e.o) begin
                    n_fail++;
                    $display("FAIL ctrl t=%0t: got state=%0d outs=%h, expected state=%0d outs=%h",
                             $time, state, a, e.st, e.o);
                end
`ifdef MCCU_PERF_EN
                n_chk++;
                if (cyc_cnt !== e.cyc || instret_cnt !== e.ins) begin
                    n_fail++;
                    $display("FAIL perf t=%0t: got cyc=%0d instret=%0d, expected cyc=%0d instret=%0d",
                             $time, cyc_cnt, instret_cnt, e.cyc, e.ins);
                end
`endif
            end
        end
    end

    initial begin
        rst = 1; mem_rdy = 1; z = 0; op = 0; func = 0;
        // two reset cycles with mem_rdy high: no writes may leak out
        cyc(1, 1, 0, 6'h00, 6'h20, 3'd0, '0, 1, 0);
        cyc(1, 1, 0, 6'h00, 6'h20, 3'd0, '0, 1, 0);
        // directed: add, lw with 2 MEM waits, sw with 1, branches both ways, jal
        run_instr(0, 0, 0, 0, 0);
        run_instr(17, 0, 2, 0, 0);
        run_instr(18, 0, 1, 0, 0);
        run_instr(19, 0, 0, 1, 0);
        run_instr(19, 0, 0, 0, 0);
        run_instr(20, 0, 0, 1, 0);
        run_instr(20, 0, 0, 0, 0);
        run_instr(22, 1, 0, 0, 0);
        // random instruction mix with random fetch/memory stalls
        for (int n = 0; n < 200; n++)
            run_instr(int'($urandom_range(0, NI - 1)), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 2)), rb(), 0);
        // reset while a store is stalled in MEM, then resume normally
        run_instr(18, 0, 1, 0, 1);
        run_instr(0, 0, 0, 0, 0);
        run_instr(21, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mccu_fsm.md
Name: mccu_fsm

Overview:
- Multi-cycle control unit for the MIPS subset already decoded by the pipelined control unit.
- Sequences one shared datapath (single ALU, single unified memory port) through IF/ID/EXE/MEM/WB.
- Each state drives write enables, mux selects and ALU control.
- Stalls on a memory-ready handshake.
- Instruction set: add sub and or xor sll srl sra sllv srlv srav jr addi andi ori xori lw sw beq bne lui j jal.

Parameters:
- ST_W, 3, state register width.
- CNT_W, 32, perf counter width (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- op  in  6  IR[31:26].
- func  in  6  IR[5:0].
- z  in  1  ALU zero flag, valid combinationally in EXE.
- mem_rdy  in  1  memory completes the current access this cycle.
- wpc  out  1  PC write enable.
- wir  out  1  IR write enable.
- wmem  out  1  memory write strobe.
- wreg  out  1  register file write enable.
- iord  out  1  memory address select: 0 = PC, 1 = ALU result register.
- regrt  out  1  destination register: 1 = rt, 0 = rd.
- m2reg  out  1  write-back data from memory.
- jal  out  1  destination forced to $31, data = PC (already PC+4).
- shift  out  1  ALU A operand = sa.
- sext  out  1  sign-extend imm16.
- alusrca  out  1  ALU A: 0 = PC, 1 = rs.
- alusrcb  out  2  ALU B: 00 = rt, 01 = 4, 10 = ext imm, 11 = ext imm<<2.
- aluc  out  4  add 0000, sub 0100, and 0001, or 0101, xor 0010, lui 0110, sll 0011, srl 0111, sra 1111.
- pcsource  out  2  00 = ALU, 01 = branch target register, 10 = rs, 11 = jump address.
- state  out  ST_W  current state, for debug.

Behaviour:
- Encoding: IF=0, ID=1, EXE=2, MEM=3, WB=4. Codes 5–7 go to IF on the next edge, with all enables 0.
- Outputs are combinational from state, op, func, z and mem_rdy. The state register is the only storage, apart from the optional counters.
- Reset: while rst=1, wpc, wir, wmem and wreg are forced to 0. The next edge sets state=IF. Reset mid-instruction abandons it with no partial write.
- IF:
  - iord=0, alusrca=0, alusrcb=01, aluc=add, pcsource=00.
  - wir=wpc=mem_rdy.
  - mem_rdy=1 → ID; otherwise hold IF with no writes.
- ID:
  - alusrca=0, alusrcb=11, sext=1, aluc=add; the datapath latches the branch target.
  - j: pcsource=11, wpc=1 → IF.
  - jal: same as j, plus wreg=1, jal=1 → IF.
  - jr: pcsource=10, wpc=1 → IF.
  - Undefined op/func: all enables 0 → IF (executes as a NOP).
  - All other instructions → EXE.
- EXE:
  - beq/bne: alusrca=1, alusrcb=00, aluc=sub, pcsource=01. wpc = z for beq, ~z for bne. → IF.
  - lw/sw: alusrca=1, alusrcb=10, sext=1, aluc=add → MEM.
  - R-type/imm ALU: aluc per the table. shift=1 for sll/srl/sra only; the variable shifts use rs. alusrcb=10 for I-type. sext=1 only for addi. lui uses B=imm, aluc=lui. → WB.
- MEM:
  - iord=1.
  - sw: wmem=1 in every MEM cycle until mem_rdy; mem_rdy → IF.
  - lw: mem_rdy → WB; otherwise hold.
- WB:
  - wreg=1, regrt=1 for I-type, m2reg=1 for lw → IF.
- CPI: j/jal/jr = 2; beq/bne = 3; ALU ops = 4; sw = 4; lw = 5. Each IF/MEM wait cycle adds 1.
- Unused selects are driven 0 in every state (never X).

Optional Feature:
- Macro MCCU_PERF_EN.
- Defined:
  - Adds outputs cyc_cnt[CNT_W] (increments every non-reset cycle) and instret_cnt[CNT_W] (increments on every transition into IF from ID/EXE/MEM/WB).
  - Both clear on rst and wrap modulo 2^CNT_W.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package mccu_pkg holds:
  - state codes;
  - aluc constants;
  - alusrcb/pcsource codes;
  - opcode and funct constants.
- Sub-module mccu_decode: purely combinational. Maps op/func to one-hot instruction flags plus an illegal flag. The FSM consumes these flags.

Test Plan:
- rst=1 for 2 cycles, then 0 → wpc=wir=wmem=wreg=0 during reset; state=0 on the first free cycle.
- add (op=0, func=0x20), mem_rdy=1 → states 0,1,2,4,0. In EXE aluc=0000, alusrcb=00. In WB wreg=1, regrt=0.
- lw (op=0x23) with mem_rdy low for 2 MEM cycles → MEM held 3 cycles, iord=1, wmem=0. WB has m2reg=1, regrt=1. Total 7 cycles.
- sw (op=0x2B), mem_rdy low for 1 MEM cycle → wmem=1 for 2 cycles, then state=IF, wreg never 1.
- beq (op=0x04): z=1 → EXE wpc=1, pcsource=01. z=0 → wpc=0. bne gives the inverse outcome.
- jal (op=0x03) → ID: wpc=1, pcsource=11, wreg=1, jal=1; next state IF. With MCCU_PERF_EN, instret_cnt increments by 1.
